// File: rtl/fft16_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft16_processor                                            |
// | Description : 16-point radix-2 decimation-in-time FFT for the audio      |
// |               visualizer. Captures 16 time samples on new_t, runs four   |
// |               butterfly stages (one per clock) and presents 16 L1 bin    |
// |               magnitudes with a done flag.                               |
// | Ports       : clk            system clock, rising edge                   |
// |               rst            synchronous reset, active high              |
// |               new_t          frame start request (accepted in IDLE)      |
// |               t0..t15        signed time samples, t0 oldest              |
// |               f0..f15        unsigned bin magnitudes, f0 = DC, f8 = Nyq. |
// |               done           results valid                               |
// | Config      : FFT_DONE_PULSE_EN - done is a one-cycle pulse instead of a |
// |               level (f0..f15 still hold).                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fft16_processor #(
  parameter int DW = 16,
  parameter int IW = 22,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_t,
  input  logic signed [DW-1:0] t0,
  input  logic signed [DW-1:0] t1,
  input  logic signed [DW-1:0] t2,
  input  logic signed [DW-1:0] t3,
  input  logic signed [DW-1:0] t4,
  input  logic signed [DW-1:0] t5,
  input  logic signed [DW-1:0] t6,
  input  logic signed [DW-1:0] t7,
  input  logic signed [DW-1:0] t8,
  input  logic signed [DW-1:0] t9,
  input  logic signed [DW-1:0] t10,
  input  logic signed [DW-1:0] t11,
  input  logic signed [DW-1:0] t12,
  input  logic signed [DW-1:0] t13,
  input  logic signed [DW-1:0] t14,
  input  logic signed [DW-1:0] t15,
  output logic        [DW-1:0] f0,
  output logic        [DW-1:0] f1,
  output logic        [DW-1:0] f2,
  output logic        [DW-1:0] f3,
  output logic        [DW-1:0] f4,
  output logic        [DW-1:0] f5,
  output logic        [DW-1:0] f6,
  output logic        [DW-1:0] f7,
  output logic        [DW-1:0] f8,
  output logic        [DW-1:0] f9,
  output logic        [DW-1:0] f10,
  output logic        [DW-1:0] f11,
  output logic        [DW-1:0] f12,
  output logic        [DW-1:0] f13,
  output logic        [DW-1:0] f14,
  output logic        [DW-1:0] f15,
  output logic                 done
);

  // Product width: IW x CW signed product plus one bit for the two-term sum.
  localparam int PW   = IW + CW + 1;
  localparam int SW   = IW + 1;
  localparam int FRAC = 14;

  localparam logic signed [PW-1:0] c_round = PW'(2 ** (FRAC - 1));
  localparam logic        [DW-1:0] c_fmax  = {DW{1'b1}};

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.14.
  localparam logic signed [CW-1:0] c_wr [8] = '{
    CW'(16384), CW'(15137), CW'(11585), CW'(6270),
    CW'(0),     CW'(-6270), CW'(-11585), CW'(-15137)
  };
  localparam logic signed [CW-1:0] c_wi [8] = '{
    CW'(0),      CW'(-6270), CW'(-11585), CW'(-15137),
    CW'(-16384), CW'(-15137), CW'(-11585), CW'(-6270)
  };

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_2    = 3'd2,
    S_3    = 3'd3,
    S_4    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_run;
  logic   w_last;
  logic [1:0] w_stage;

  logic signed [IW-1:0] r_re [16];
  logic signed [IW-1:0] r_im [16];
  logic        [DW-1:0] r_f  [16];
  logic                 r_done;

  logic signed [DW-1:0] w_t     [16];
  logic signed [IW-1:0] w_bf_re [16];
  logic signed [IW-1:0] w_bf_im [16];
  logic        [DW-1:0] w_mag   [16];

  assign w_t = '{t0, t1, t2, t3, t4, t5, t6, t7,
                 t8, t9, t10, t11, t12, t13, t14, t15};

  function automatic logic [3:0] f_rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_last      = 1'b0;
    w_stage     = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (new_t) begin
          w_load      = 1'b1;
          w_state_nxt = S_1;
        end
      end
      S_1: begin
        w_run       = 1'b1;
        w_stage     = 2'd0;
        w_state_nxt = S_2;
      end
      S_2: begin
        w_run       = 1'b1;
        w_stage     = 2'd1;
        w_state_nxt = S_3;
      end
      S_3: begin
        w_run       = 1'b1;
        w_stage     = 2'd2;
        w_state_nxt = S_4;
      end
      S_4: begin
        w_run       = 1'b1;
        w_last      = 1'b1;
        w_stage     = 2'd3;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- butterflies
  // One stage of 8 butterflies, span 2^stage. Butterfly n pairs index
  // ia (n with a zero inserted at bit 'stage') with ib = ia + span; the
  // twiddle exponent is the position inside the group scaled to 16 points.
  always_comb begin
    logic [4:0]           w_h;
    logic [3:0]           w_ia;
    logic [3:0]           w_ib;
    logic [2:0]           w_k;
    logic signed [PW-1:0] w_acc_re;
    logic signed [PW-1:0] w_acc_im;
    logic signed [IW-1:0] w_wb_re;
    logic signed [IW-1:0] w_wb_im;

    w_bf_re  = r_re;
    w_bf_im  = r_im;
    w_h      = 5'd1 << w_stage;
    w_ia     = 4'd0;
    w_ib     = 4'd0;
    w_k      = 3'd0;
    w_acc_re = '0;
    w_acc_im = '0;
    w_wb_re  = '0;
    w_wb_im  = '0;
    for (int n = 0; n < 8; n++) begin
      w_ia = 4'(((n >> w_stage) << (w_stage + 2'd1)) | (n & (int'(w_h) - 1)));
      w_ib = w_ia + 4'(w_h);
      w_k  = 3'((n & (int'(w_h) - 1)) << (2'd3 - w_stage));
      // One rounding per component keeps W0 and W4 exact.
      w_acc_re = PW'(r_re[w_ib]) * PW'(c_wr[w_k])
               - PW'(r_im[w_ib]) * PW'(c_wi[w_k]) + c_round;
      w_acc_im = PW'(r_re[w_ib]) * PW'(c_wi[w_k])
               + PW'(r_im[w_ib]) * PW'(c_wr[w_k]) + c_round;
      w_wb_re  = IW'(w_acc_re >>> FRAC);
      w_wb_im  = IW'(w_acc_im >>> FRAC);
      w_bf_re[w_ia] = r_re[w_ia] + w_wb_re;
      w_bf_im[w_ia] = r_im[w_ia] + w_wb_im;
      w_bf_re[w_ib] = r_re[w_ia] - w_wb_re;
      w_bf_im[w_ib] = r_im[w_ia] - w_wb_im;
    end
  end

  // ------------------------------------------------ L1 magnitude + sat
  always_comb begin
    logic [IW-1:0] w_abs_re;
    logic [IW-1:0] w_abs_im;
    logic [SW-1:0] w_sum;

    w_abs_re = '0;
    w_abs_im = '0;
    w_sum    = '0;
    for (int i = 0; i < 16; i++) begin
      w_abs_re = w_bf_re[i][IW-1] ? IW'(-w_bf_re[i]) : IW'(w_bf_re[i]);
      w_abs_im = w_bf_im[i][IW-1] ? IW'(-w_bf_im[i]) : IW'(w_bf_im[i]);
      w_sum    = {1'b0, w_abs_re} + {1'b0, w_abs_im};
      w_mag[i] = (w_sum > SW'(c_fmax)) ? c_fmax : DW'(w_sum);
    end
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
        r_f[i]  <= '0;
      end
      r_done <= 1'b0;
    end else begin
`ifdef FFT_DONE_PULSE_EN
      r_done <= 1'b0;
`endif
      if (w_load) begin
        // DIT needs the input in bit-reversed order.
        for (int i = 0; i < 16; i++) begin
          r_re[i] <= IW'(w_t[f_rev4(4'(i))]);
          r_im[i] <= '0;
        end
        r_done <= 1'b0;
      end else if (w_run) begin
        r_re <= w_bf_re;
        r_im <= w_bf_im;
      end
      // The last stage goes straight into the magnitude registers.
      if (w_last) begin
        for (int i = 0; i < 16; i++) begin
          r_f[i] <= w_mag[i];
        end
        r_done <= 1'b1;
      end
    end
  end

  assign f0   = r_f[0];
  assign f1   = r_f[1];
  assign f2   = r_f[2];
  assign f3   = r_f[3];
  assign f4   = r_f[4];
  assign f5   = r_f[5];
  assign f6   = r_f[6];
  assign f7   = r_f[7];
  assign f8   = r_f[8];
  assign f9   = r_f[9];
  assign f10  = r_f[10];
  assign f11  = r_f[11];
  assign f12  = r_f[12];
  assign f13  = r_f[13];
  assign f14  = r_f[14];
  assign f15  = r_f[15];
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft16_processor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fft16_processor                                         |
// | Description : Self-checking bench for fft16_processor. Expected bins come|
// |               from an ideal floating-point DFT pushed to a scoreboard at |
// |               frame load and popped when done is checked.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fft16_processor;

  localparam int  DW = 16;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 new_t;
  logic signed [DW-1:0] t [16];
  logic        [DW-1:0] f [16];
  logic                 done;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  tv [16];
  real q_exp [$];
  real q_tol [$];

  always #5 clk = ~clk;

  fft16_processor dut (
    .clk(clk), .rst(rst), .new_t(new_t),
    .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]),
    .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
    .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]),
    .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
    .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]),
    .f4(f[4]), .f5(f[5]), .f6(f[6]), .f7(f[7]),
    .f8(f[8]), .f9(f[9]), .f10(f[10]), .f11(f[11]),
    .f12(f[12]), .f13(f[13]), .f14(f[14]), .f15(f[15]),
    .done(done)
  );

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_t();
    for (int i = 0; i < 16; i++) t[i] = 16'(tv[i]);
  endtask

  task automatic set_pat4(input int a, input int b, input int c, input int d);
    for (int i = 0; i < 16; i += 4) begin
      tv[i] = a; tv[i+1] = b; tv[i+2] = c; tv[i+3] = d;
    end
  endtask

  // Ideal L1 magnitudes of the current tv; DC and Nyquist must be exact.
  task automatic push_ideal(input real tol);
    real re, im;
    for (int k = 0; k < 16; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 16; n++) begin
        re += real'(tv[n]) * $cos(2.0 * PI * k * n / 16.0);
        im -= real'(tv[n]) * $sin(2.0 * PI * k * n / 16.0);
      end
      q_exp.push_back(rabs(re) + rabs(im));
      q_tol.push_back((k == 0 || k == 8) ? 0.01 : tol);
    end
  endtask

  task automatic check_frame(input string tag);
    real e, tl, d;
    if (q_exp.size() < 16) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard holds %0d entries, need 16", tag, q_exp.size());
      return;
    end
    for (int k = 0; k < 16; k++) begin
      e  = q_exp.pop_front();
      tl = q_tol.pop_front();
      d  = rabs(real'(f[k]) - e);
      n_assert++;
      assert ((d <= tl) === 1'b1) else begin
        n_fail++;
        $error("FAIL %s f%0d: observed %0d expected %0.3f (tol %0.2f)", tag, k, f[k], e, tl);
      end
    end
  endtask

  // Load on the next edge, then four stage edges; done must rise on edge 5.
  task automatic run_frame(input string tag);
    new_t = 1'b1;
    tick();
    new_t = 1'b0;
    chk({tag, " done cleared at load"}, int'(done), 0);
    tick(); tick(); tick();
    chk({tag, " done before edge 5"}, int'(done), 0);
    tick();
    chk({tag, " done at edge 5"}, int'(done), 1);
    check_frame(tag);
  endtask

  initial begin
    rst   = 1'b1;
    new_t = 1'b0;
    for (int i = 0; i < 16; i++) tv[i] = 0;
    drive_t();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("reset done", int'(done), 0);
    for (int k = 0; k < 16; k++) chk($sformatf("reset f%0d", k), int'(f[k]), 0);

    // A: {10,0} repeated -> f0 = f8 = 80
    set_pat4(10, 0, 10, 0);
    drive_t();
    push_ideal(0.01);
    run_frame("A");
    chk("A f0 literal", int'(f[0]), 80);
    chk("A f8 literal", int'(f[8]), 80);
    tick(); tick();
    chk("A done holds", int'(done), 1);
    chk("A f0 holds", int'(f[0]), 80);

    // B: {10,5,10,3} repeated -> f0 112, f8 48, f4 = f12 = 8
    set_pat4(10, 5, 10, 3);
    drive_t();
    push_ideal(0.01);
    run_frame("B");
    chk("B f4 literal", int'(f[4]), 8);
    chk("B f12 literal", int'(f[12]), 8);

    // C: rectangular window, non-trivial twiddles, +/-2 LSB
    for (int i = 0; i < 16; i++) tv[i] = ((i <= 4) || (i >= 8 && i <= 11)) ? 500 : 0;
    drive_t();
    push_ideal(2.0);
    run_frame("C");
    chk("C f0 literal", int'(f[0]), 4500);
    chk("C f8 literal", int'(f[8]), 500);

    // D: new_t and new samples during S2 are ignored
    set_pat4(10, 0, 10, 0);
    drive_t();
    push_ideal(0.01);
    new_t = 1'b1;
    tick();                     // edge 1: load
    new_t = 1'b0;
    tick();                     // edge 2: now in S2
    set_pat4(10, 5, 10, 3);
    drive_t();
    new_t = 1'b1;
    tick();                     // edge 3: in S2, must be ignored
    new_t = 1'b0;
    tick();                     // edge 4
    chk("D done before edge 5", int'(done), 0);
    tick();                     // edge 5
    chk("D done at edge 5", int'(done), 1);
    check_frame("D");
    tick(); tick(); tick(); tick(); tick();
    chk("D no phantom frame", int'(done), 1);

    // E: reset during S3 aborts the frame
    set_pat4(7, 3, -2, 9);
    drive_t();
    new_t = 1'b1;
    tick();                     // edge 1: load
    new_t = 1'b0;
    tick(); tick();             // edges 2,3: now in S3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E done after abort", int'(done), 0);
    for (int k = 0; k < 16; k++) chk($sformatf("E f%0d after abort", k), int'(f[k]), 0);
    tick(); tick(); tick();
    chk("E no late done", int'(done), 0);
    set_pat4(10, 5, 10, 3);
    drive_t();
    push_ideal(0.01);
    run_frame("E");

    // F: new_t held high restarts from IDLE; t is sampled only at load
    set_pat4(10, 0, 10, 0);
    drive_t();
    push_ideal(0.01);
    new_t = 1'b1;
    tick();                     // edge 1: load frame 1
    set_pat4(10, 5, 10, 3);
    drive_t();
    push_ideal(0.01);
    tick(); tick(); tick();
    tick();                     // edge 5
    chk("F1 done at edge 5", int'(done), 1);
    check_frame("F1");
    tick();                     // edge 6: reload since new_t still high
    new_t = 1'b0;
    chk("F2 done cleared at reload", int'(done), 0);
    tick(); tick(); tick();
    chk("F2 done before edge 5", int'(done), 0);
    tick();
    chk("F2 done at edge 5", int'(done), 1);
    check_frame("F2");

    // G: rst and new_t on the same edge, rst wins
    rst   = 1'b1;
    new_t = 1'b1;
    tick();
    rst   = 1'b0;
    new_t = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("G rst beats new_t done", int'(done), 0);
    chk("G rst beats new_t f0", int'(f[0]), 0);

    chk("scoreboard drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
